// File: rtl/image_stream_loader.sv
// Pixel stream loader: assembles one image from a valid/ready pixel stream and holds it for Main until finish.
// Optional build macro PIXEL_CLAMP_EN clamps each accepted pixel into [0, Inf] before it is stored.
module image_stream_loader #(
  parameter int                   bitlength = 12,
  parameter int                   input_dim = 784,
  parameter logic [bitlength-1:0] Inf       = 12'b0111_1111_1111
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [bitlength-1:0]           pixel_in,
  input  logic                           pixel_valid,
  output logic                           pixel_ready,
  input  logic                           finish,
  output logic                           data_valid,
  output logic [input_dim*bitlength-1:0] InputDataPort,
  output logic [$clog2(input_dim+1)-1:0] pix_count,
  output logic [15:0]                    image_count
);

  localparam int                CNT_W    = $clog2(input_dim + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(input_dim - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [CNT_W-1:0]               r_pix_count;
  logic [input_dim*bitlength-1:0] r_buffer;
  logic                           r_finish_d;
  logic [15:0]                    r_image_count;
  logic                           w_accept;
  logic                           w_finish_rise;
  logic [bitlength-1:0]           w_pixel_store;

  function automatic logic [bitlength-1:0] f_clamp(input logic [bitlength-1:0] px);
    if (px[bitlength-1])
      return '0;
    else if (px > Inf)
      return Inf;
    else
      return px;
  endfunction

`ifdef PIXEL_CLAMP_EN
  assign w_pixel_store = f_clamp(pixel_in);
`else
  assign w_pixel_store = pixel_in;
`endif

  assign w_finish_rise = finish & ~r_finish_d;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    pixel_ready  = 1'b0;
    data_valid   = 1'b0;
    unique case (r_state)
      LOAD: begin
        pixel_ready = 1'b1;
        w_accept    = pixel_valid;
        if (pixel_valid && (r_pix_count == LAST_IDX))
          w_state_next = HOLD;
      end
      HOLD: begin
        data_valid = 1'b1;
        if (w_finish_rise)
          w_state_next = RELEASE;
      end
      RELEASE: w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= LOAD;
      r_pix_count   <= '0;
      r_finish_d    <= 1'b0;
      r_image_count <= '0;
      // NOTE: the image buffer is plain flops, not a RAM, so it can be reset; a partial image must not leak.
      r_buffer      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_finish_d <= finish;
      if (w_accept) begin
        r_buffer[int'(r_pix_count)*bitlength +: bitlength] <= w_pixel_store;
        r_pix_count <= r_pix_count + CNT_W'(1);
      end
      if (r_state == RELEASE)
        r_pix_count <= '0;
      if ((r_state == HOLD) && w_finish_rise)
        r_image_count <= r_image_count + 16'd1;
    end
  end

  assign InputDataPort = r_buffer;
  assign pix_count     = r_pix_count;
  assign image_count   = r_image_count;

endmodule

// File: doc/image_stream_loader.md
Name: image_stream_loader

Overview:
- Upstream feeder for Main.
- Accepts one pixel per cycle over a valid/ready stream and assembles a full image in a register buffer.
- Drives the packed InputDataPort and a level data_valid into Main.
- Holds the image stable until Main pulses finish, then accepts the next image.

Parameters:
bitlength, 12, width of one pixel word (fixed-point, same format as Main)
input_dim, 784, pixels per image (64 when building the sparse configuration)
Inf, 12'b0111_1111_1111, positive saturation value used by the optional clamp

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
pixel_in  input  bitlength  incoming pixel word
pixel_valid  input  1  pixel_in is valid this cycle
pixel_ready  output  1  loader accepts a pixel this cycle
finish  input  1  Main's finish flag (level; loader edge-detects)
data_valid  output  1  image complete and stable; level to Main
InputDataPort  output  input_dim*bitlength  packed image, pixel k at bits [k*bitlength +: bitlength]
pix_count  output  clog2(input_dim+1)  pixels accepted in current image
image_count  output  16  images handed to Main since reset, wraps at 65535->0

Behaviour:
- Reset (synchronous, active-high, wins over all other events):
  - state=LOAD; pix_count=0; buffer all-zero; data_valid=0; pixel_ready=1 on the first cycle after reset; image_count=0; finish_d=0.
- States:
  - LOAD: pixel_ready=1, data_valid=0.
  - HOLD: pixel_ready=0, data_valid=1.
  - RELEASE: pixel_ready=0, data_valid=0, single cycle.
- LOAD:
  - A transfer occurs on a cycle with pixel_valid & pixel_ready.
  - On a transfer, the word is written to slot pix_count and pix_count increments.
  - pixel_valid with pixel_ready=0 is ignored (no write, no count).
- Last pixel: a transfer at pix_count==input_dim-1 writes slot input_dim-1, sets pix_count=input_dim, and moves to HOLD.
  - data_valid rises the cycle after the last transfer (latency 1 from final accept).
- HOLD:
  - InputDataPort is frozen; no buffer writes.
  - Leave HOLD on the finish rising edge (finish & ~finish_d, where finish_d is finish registered every cycle).
  - On that edge: image_count increments and state goes to RELEASE.
  - A finish level that is already high on entry to HOLD does not count; only a fresh rising edge does.
- RELEASE:
  - Clears pix_count to 0, then enters LOAD next cycle.
  - Buffer contents are not cleared; they are overwritten slot by slot.
  - Guarantees data_valid is low for at least one cycle so Main re-arms.
- finish edge while in LOAD or RELEASE: ignored, only finish_d updates.
- Reset mid-image or mid-HOLD: partial image discarded, all state as per reset, data_valid falls the next edge.
- input_dim==1: the first transfer goes straight to HOLD.
- InputDataPort is purely the register buffer, with no combinational path from pixel_in.

Optional Feature:
- Macro: PIXEL_CLAMP_EN
- Defined:
  - Each accepted pixel is clamped before storage.
  - MSB set (negative in two's complement) stores 0.
  - Values above Inf store Inf. With default widths only negatives are affected.
  - Clamping adds no latency.
- Undefined: pixel_in is stored unmodified.

Test Plan:
- Reset, input_dim=4, stream 12'h001,12'h002,12'h003,12'h004 back-to-back -> data_valid=1 one cycle after 4th accept; InputDataPort=48'h004_003_002_001; pix_count=4; pixel_ready=0.
- Same image with pixel_valid gapped every other cycle -> identical InputDataPort; only valid cycles counted; pix_count steps 0..4.
- In HOLD, drive pixel_valid=1 with 12'hFFF for 5 cycles -> InputDataPort unchanged. Pulse finish 1 cycle -> RELEASE one cycle with data_valid=0, then LOAD with pixel_ready=1; image_count=1.
- Hold finish high continuously across a complete second image -> loader stays in HOLD after image 2 until finish drops and rises again; image_count increments only on that edge.
- Reset asserted after 2 of 4 pixels -> next cycle pix_count=0, buffer zero, data_valid=0. A fresh 4-pixel image then loads correctly.
- With PIXEL_CLAMP_EN, stream 12'h800,12'hFFF,12'h7FF,12'h123 -> stored 12'h000,12'h000,12'h7FF,12'h123. Without the macro all four are stored verbatim.
